// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RAM port arbiter and its read tracker.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_RD_DEF = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM local-side signals of the arbiter; slave = arbiter, master = environment.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic                local_init_done;
  logic                local_ready;
  logic [DATA_W-1:0]   local_rdata;
  logic                local_rdata_valid;
  logic [ADDR_W-1:0]   local_address;
  logic [DATA_W-1:0]   local_wdata;
  logic [DATA_W/8-1:0] local_be;
  logic                local_size;
  logic                local_burstbegin;
  logic                local_write_req;
  logic                local_read_req;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output wr_ack, rd_ack, rd_data, rd_valid,
    output local_address, local_wdata, local_be, local_size,
    output local_burstbegin, local_write_req, local_read_req
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  wr_ack, rd_ack, rd_data, rd_valid,
    input  local_address, local_wdata, local_be, local_size,
    input  local_burstbegin, local_write_req, local_read_req
  );

endinterface

// File: rtl/ram_rd_tracker.sv
// Counts reads in flight, forwards returned read data one cycle later and flags unexpected data.
module ram_rd_tracker
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_RD = MAX_RD_DEF
) (
  input  logic              phy_clk,
  input  logic              reset,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [7:0]        rd_outstanding,
  output logic              err_unexpected
);

  localparam logic [7:0] MAX_RD_C = 8'(MAX_RD);

  logic [7:0]        count_q, count_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    err_d   = err_q;
    valid_d = local_rdata_valid;
    data_d  = local_rdata_valid ? local_rdata : data_q;

    // Data with nothing in flight is still forwarded; only the sticky flag records it.
    if (local_rdata_valid && (count_q == 8'd0)) err_d = 1'b1;

    case ({rd_ack, local_rdata_valid})
      2'b10:   if (count_q < MAX_RD_C) count_d = count_q + 8'd1;
      2'b01:   if (count_q != 8'd0)    count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      count_q <= 8'd0;
      err_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_outstanding = count_q;
  assign err_unexpected = err_q;
  assign rd_data        = data_q;
  assign rd_valid       = valid_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM local port between a write and a read requester.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_RD = MAX_RD_DEF
) (
  input  logic               phy_clk,
  input  logic               reset,
  ram_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic [7:0]         rd_outstanding,
  output logic               err_unexpected
);

  localparam logic [7:0] MAX_RD_C = 8'(MAX_RD);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_cmd_q, wr_cmd_d;
  logic              rd_cmd_q, rd_cmd_d;

  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic wr_ack, rd_ack;

  // Acks are suppressed while reset is high so an abandoned command is never reported accepted.
  assign wr_ack = (state_q == ST_WRITE) && bus.local_ready && !reset;
  assign rd_ack = (state_q == ST_READ)  && bus.local_ready && !reset;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_cmd_d = wr_cmd_q;
    rd_cmd_d = rd_cmd_q;

    wr_elig  = bus.wr_req;
    rd_elig  = bus.rd_req && (rd_outstanding < MAX_RD_C);
    grant_wr = wr_elig && (!rd_elig || (last_q == GRANT_RD));
    grant_rd = rd_elig && !grant_wr;

    case (state_q)
      ST_INIT: begin
        if (bus.local_init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (grant_wr) begin
          state_d  = ST_WRITE;
          addr_d   = bus.wr_addr;
          wdata_d  = bus.wr_data;
          wr_cmd_d = 1'b1;
        end else if (grant_rd) begin
          state_d  = ST_READ;
          addr_d   = bus.rd_addr;
          rd_cmd_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (bus.local_ready) begin
          state_d  = ST_IDLE;
          wr_cmd_d = 1'b0;
          last_d   = GRANT_WR;
        end
      end
      ST_READ: begin
        if (bus.local_ready) begin
          state_d  = ST_IDLE;
          rd_cmd_d = 1'b0;
          last_d   = GRANT_RD;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      last_q   <= GRANT_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_cmd_q <= 1'b0;
      rd_cmd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_cmd_q <= wr_cmd_d;
      rd_cmd_q <= rd_cmd_d;
    end
  end

  ram_rd_tracker #(
    .DATA_W (DATA_W),
    .MAX_RD (MAX_RD)
  ) u_rd_tracker (
    .phy_clk           (phy_clk),
    .reset             (reset),
    .rd_ack            (rd_ack),
    .local_rdata       (bus.local_rdata),
    .local_rdata_valid (bus.local_rdata_valid),
    .rd_data           (bus.rd_data),
    .rd_valid          (bus.rd_valid),
    .rd_outstanding    (rd_outstanding),
    .err_unexpected    (err_unexpected)
  );

  assign bus.wr_ack           = wr_ack;
  assign bus.rd_ack           = rd_ack;
  assign bus.local_address    = addr_q;
  assign bus.local_wdata      = wdata_q;
  assign bus.local_write_req  = wr_cmd_q;
  assign bus.local_read_req   = rd_cmd_q;
  assign bus.local_burstbegin = wr_cmd_q | rd_cmd_q;
  assign bus.local_size       = 1'b1;
  assign bus.local_be         = '1;
  assign busy                 = wr_cmd_q | rd_cmd_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter: init gating, round-robin, stalls, read limit, errors.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic       phy_clk;
  logic       reset;
  logic       busy;
  logic [7:0] rd_outstanding;
  logic       err_unexpected;

  int tests_run    = 0;
  int tests_failed = 0;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .phy_clk        (phy_clk),
    .reset          (reset),
    .bus            (bus.slave),
    .busy           (busy),
    .rd_outstanding (rd_outstanding),
    .err_unexpected (err_unexpected)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0] rr_exp [8];

  initial begin
    int  cnt_a;
    int  cnt_b;
    bit  got;

    rr_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    reset                 = 1'b1;
    bus.wr_req            = 1'b0;
    bus.wr_addr           = '0;
    bus.wr_data           = '0;
    bus.rd_req            = 1'b0;
    bus.rd_addr           = '0;
    bus.local_init_done   = 1'b0;
    bus.local_ready       = 1'b0;
    bus.local_rdata       = '0;
    bus.local_rdata_valid = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_wreq",   bus.local_write_req,  0);
    check("rst_rreq",   bus.local_read_req,   0);
    check("rst_bb",     bus.local_burstbegin, 0);
    check("rst_addr",   bus.local_address,    0);
    check("rst_busy",   busy,                 0);
    check("rst_cnt",    rd_outstanding,       0);
    check("rst_err",    err_unexpected,       0);
    check("rst_size",   bus.local_size,       1);
    check("rst_be",     bus.local_be,         4'hF);
    check("rst_rvalid", bus.rd_valid,         0);

    // Init gating with both requesters waiting
    reset       = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000010;
    bus.wr_data = 32'h0BADF00D;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h000020;
    cnt_a = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.local_write_req) cnt_a++;
    end
    check("init_gate", cnt_a, 0);
    bus.local_init_done = 1'b1;
    tick();
    check("init_idle_wreq", bus.local_write_req, 0);
    check("init_idle_busy", busy, 0);
    tick();
    check("init_wreq",  bus.local_write_req,  1);
    check("init_rreq",  bus.local_read_req,   0);
    check("init_bb",    bus.local_burstbegin, 1);
    check("init_busy",  busy,                 1);
    check("first_addr", bus.local_address,    24'h000010);

    // Tie and round-robin: W,R,W,R one command per two cycles
    bus.local_ready = 1'b1;
    settle();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_ack_%0d", i), {bus.wr_ack, bus.rd_ack}, rr_exp[i]);
      if (i == 0) check("rr_wdata", bus.local_wdata, 32'h0BADF00D);
      if (i == 2) check("rr_raddr", bus.local_address, 24'h000020);
      if (i == 6) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
      tick();
    end
    check("rr_cnt", rd_outstanding, 2);

    // Ready stall: command held 8 cycles, single ack
    bus.wr_req      = 1'b1;
    bus.wr_addr     = 24'h000ABC;
    bus.wr_data     = 32'hDEADBEEF;
    bus.local_ready = 1'b0;
    tick();
    cnt_a = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        bus.local_ready = 1'b1;
        bus.wr_req      = 1'b0;
        settle();
      end
      check($sformatf("stall_wreq_%0d", k),  bus.local_write_req, 1);
      check($sformatf("stall_addr_%0d", k),  bus.local_address,   24'h000ABC);
      check($sformatf("stall_wdata_%0d", k), bus.local_wdata,     32'hDEADBEEF);
      if (bus.wr_ack) cnt_a++;
      tick();
    end
    check("stall_acks",      cnt_a, 1);
    check("stall_post_wreq", bus.local_write_req, 0);
    check("stall_post_ack",  bus.wr_ack, 0);

    // Return the two outstanding reads; data appears one cycle later
    bus.local_rdata_valid = 1'b1;
    bus.local_rdata       = 32'h000000A1;
    tick();
    bus.local_rdata = 32'h000000A2;
    check("drain_v1", bus.rd_valid, 1);
    check("drain_d1", bus.rd_data,  32'h000000A1);
    tick();
    bus.local_rdata_valid = 1'b0;
    check("drain_v2", bus.rd_valid, 1);
    check("drain_d2", bus.rd_data,  32'h000000A2);
    tick();
    check("drain_v0",  bus.rd_valid,    0);
    check("drain_cnt", rd_outstanding,  0);
    check("drain_err", err_unexpected,  0);

    // Outstanding limit
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h000100;
    cnt_a = 0;
    for (int i = 0; i < 40 && cnt_a < 8; i++) begin
      tick();
      if (bus.rd_ack) cnt_a++;
    end
    check("lim_acks", cnt_a, 8);
    tick();
    check("lim_cnt8", rd_outstanding, 8);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000200;
    bus.wr_data = 32'h00000055;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.wr_ack) begin
        cnt_a++;
        bus.wr_req = 1'b0;
      end
      if (bus.rd_ack) cnt_b++;
    end
    check("lim_wr_granted", cnt_a, 1);
    check("lim_rd_blocked", cnt_b, 0);
    check("lim_cnt_hold",   rd_outstanding, 8);
    bus.local_rdata_valid = 1'b1;
    bus.local_rdata       = 32'h00000077;
    tick();
    bus.local_rdata_valid = 1'b0;
    check("lim_cnt7", rd_outstanding, 7);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.rd_ack) begin
        got        = 1'b1;
        bus.rd_req = 1'b0;
      end
    end
    check("lim_rd_after", got, 1);
    tick();
    check("lim_cnt8b", rd_outstanding, 8);

    // Read ack and returning data in the same cycle
    bus.local_rdata_valid = 1'b1;
    repeat (5) tick();
    bus.local_rdata_valid = 1'b0;
    check("sim_pre", rd_outstanding, 3);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h000300;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.local_read_req) begin
        got                   = 1'b1;
        bus.local_rdata_valid = 1'b1;
        bus.local_rdata       = 32'h12345678;
        bus.rd_req            = 1'b0;
        settle();
        check("sim_ack", bus.rd_ack, 1);
      end
    end
    check("sim_reached", got, 1);
    tick();
    bus.local_rdata_valid = 1'b0;
    check("sim_cnt",    rd_outstanding, 3);
    check("sim_rvalid", bus.rd_valid,   1);
    check("sim_rdata",  bus.rd_data,    32'h12345678);

    // Unexpected read data
    bus.local_rdata_valid = 1'b1;
    repeat (3) tick();
    bus.local_rdata_valid = 1'b0;
    check("err_cnt0", rd_outstanding, 0);
    check("err_pre",  err_unexpected, 0);
    bus.local_rdata_valid = 1'b1;
    bus.local_rdata       = 32'h000000E1;
    tick();
    bus.local_rdata_valid = 1'b0;
    check("err_set",    err_unexpected, 1);
    check("err_cnt",    rd_outstanding, 0);
    check("err_rvalid", bus.rd_valid,   1);
    check("err_rdata",  bus.rd_data,    32'h000000E1);
    repeat (5) tick();
    check("err_sticky", err_unexpected, 1);

    // Reset in the middle of a stalled write
    bus.wr_req      = 1'b1;
    bus.wr_addr     = 24'h000400;
    bus.local_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      if (bus.local_write_req) got = 1'b1;
    end
    check("mid_reached", got, 1);
    reset           = 1'b1;
    bus.local_ready = 1'b1;
    settle();
    check("mid_no_ack", bus.wr_ack, 0);
    tick();
    check("mid_wreq", bus.local_write_req, 0);
    check("mid_busy", busy,                0);
    check("mid_err",  err_unexpected,      0);
    reset      = 1'b0;
    bus.wr_req = 1'b0;
    bus.local_rdata_valid = 1'b1;
    tick();
    bus.local_rdata_valid = 1'b0;
    check("mid_late_data_err", err_unexpected, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
